// File: rtl/vga_pixel_render.sv
// vga_pixel_render: two-stage breakout pixel colouring (bricks, paddle, ball) with brick bitmap
// and syncs delayed to match the colour pipeline.
module vga_pixel_render #(
   parameter int H_ACT_START = 144,
   parameter int H_ACT       = 640,
   parameter int V_ACT_START = 31,
   parameter int V_ACT       = 480,
   parameter int BRICK_COLS  = 8,
   parameter int BRICK_ROWS  = 3,
   parameter int BRICK_W     = 80,
   parameter int BRICK_H     = 20,
   parameter int BRICK_TOP   = 40,
   parameter int PADDLE_Y    = 440,
   parameter int PADDLE_W    = 64,
   parameter int PADDLE_H    = 8,
   parameter int BALL_SZ     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [10:0] hpos,
   input  logic [10:0] vpos,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [9:0]  paddle_x,
   input  logic [9:0]  ball_x,
   input  logic [8:0]  ball_y,
   input  logic        clr_valid,
   input  logic [4:0]  clr_idx,
   output logic        clr_ready,
   input  logic        load_all,
   output logic        all_clear,
   output logic [7:0]  rgb,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        frame_start
);
   localparam int NBRICK = BRICK_COLS * BRICK_ROWS;
   localparam logic [10:0] HS = 11'(H_ACT_START);
   localparam logic [10:0] HE = 11'(H_ACT_START + H_ACT);
   localparam logic [10:0] VS = 11'(V_ACT_START);
   localparam logic [10:0] VE = 11'(V_ACT_START + V_ACT);

   logic act_q, act_d, vact_q, vact_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
   logic [9:0] x_q, x_d, px_q, px_d, bx_q, bx_d, xoff_q, xoff_d, dx;
   logic [8:0] y_q, y_d, by_q, by_d, dy;
   logic [4:0] col_q, col_d, row, idx;
   logic [NBRICK-1:0] alive_q, alive_d;
   logic all_clear_q, all_clear_d, hs2_q, hs2_d, vs2_q, vs2_d, fs2_q, fs2_d;
   logic [7:0] rgb_q, rgb_d, brick_rgb;
   logic wrap, row_hit, row_top, ball, pad, brick;

   assign clr_ready = enable & ~vact_q;

   always_comb begin
      vact_d = vpos >= VS && vpos < VE;
      act_d = vact_d && hpos >= HS && hpos < HE;
      x_d = 10'(hpos - HS);
      y_d = 9'(vpos - VS);
      hs1_d = hsync_in;
      vs1_d = vsync_in;
      fs1_d = hpos == 11'd0 && vpos == 11'd0;
      px_d = paddle_x;
      bx_d = ball_x;
      by_d = ball_y;
      // brick column and offset tracked along the line instead of dividing x
      wrap = xoff_q == 10'(BRICK_W - 1);
      col_d = hpos == HS ? 5'd0 : wrap ? col_q + 5'd1 : col_q;
      xoff_d = (hpos == HS || wrap) ? 10'd0 : xoff_q + 10'd1;
      alive_d = load_all ? '1 :
                (clr_valid && clr_ready) ? alive_q & ~(NBRICK'(1) << clr_idx) : alive_q;
      all_clear_d = alive_q == '0;
      row_hit = 1'b0;
      row_top = 1'b0;
      row = 5'd0;
      for (int r = 0; r < BRICK_ROWS; r++)
         if (y_q >= 9'(BRICK_TOP + r * BRICK_H) && y_q < 9'(BRICK_TOP + (r + 1) * BRICK_H)) begin
            row_hit = 1'b1;
            row_top = y_q == 9'(BRICK_TOP + r * BRICK_H);
            row = 5'(r);
         end
      idx = 5'(row * BRICK_COLS) + col_q;
      brick = row_hit && col_q < 5'(BRICK_COLS) && alive_q[idx] && xoff_q != 10'd0 && !row_top;
      brick_rgb = row == 5'd0 ? 8'hE0 : row == 5'd1 ? 8'hFC : 8'h1C;
      dx = x_q - bx_q;
      dy = y_q - by_q;
      ball = dx < 10'(BALL_SZ) && dy < 9'(BALL_SZ);
      pad = x_q >= px_q && {1'b0, x_q} < {1'b0, px_q} + 11'(PADDLE_W) &&
            y_q >= 9'(PADDLE_Y) && y_q < 9'(PADDLE_Y + PADDLE_H);
      rgb_d = !act_q ? 8'h00 : ball ? 8'hFF : pad ? 8'h1F : brick ? brick_rgb : 8'h02;
      hs2_d = hs1_q;
      vs2_d = vs1_q;
      fs2_d = fs1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         act_q <= 1'b0;
         vact_q <= 1'b0;
         hs1_q <= 1'b1;
         vs1_q <= 1'b1;
         fs1_q <= 1'b0;
         x_q <= '0;
         y_q <= '0;
         px_q <= '0;
         bx_q <= '0;
         by_q <= '0;
         xoff_q <= '0;
         col_q <= '0;
         alive_q <= '1;
         all_clear_q <= 1'b0;
         rgb_q <= 8'h00;
         hs2_q <= 1'b1;
         vs2_q <= 1'b1;
         fs2_q <= 1'b0;
      end else if (enable) begin
         act_q <= act_d;
         vact_q <= vact_d;
         hs1_q <= hs1_d;
         vs1_q <= vs1_d;
         fs1_q <= fs1_d;
         x_q <= x_d;
         y_q <= y_d;
         px_q <= px_d;
         bx_q <= bx_d;
         by_q <= by_d;
         xoff_q <= xoff_d;
         col_q <= col_d;
         alive_q <= alive_d;
         all_clear_q <= all_clear_d;
         rgb_q <= rgb_d;
         hs2_q <= hs2_d;
         vs2_q <= vs2_d;
         fs2_q <= fs2_d;
      end
   end

   assign all_clear = all_clear_q;
   assign rgb = rgb_q;
   assign hsync_out = hs2_q;
   assign vsync_out = vs2_q;
   assign frame_start = fs2_q;
endmodule

// File: tb/tb_vga_pixel_render.sv
// tb_vga_pixel_render: vector probes, corner-case sequences and a per-tick reference model
// of the breakout pixel renderer.
module tb_vga_pixel_render;
   logic clk = 1'b0;
   logic reset, enable, hsync_in, vsync_in, clr_valid, load_all;
   logic [10:0] hpos, vpos;
   logic [9:0] paddle_x, ball_x;
   logic [8:0] ball_y;
   logic [4:0] clr_idx;
   logic clr_ready, all_clear, hsync_out, vsync_out, frame_start;
   logic [7:0] rgb;
   int n_chk = 0, n_fail = 0, fs_count = 0;

   logic m_val, m_hs, m_vs, m_hso, m_vso, m_fs, m_allc;
   int m_h, m_v, m_px, m_bx, m_by;
   logic [7:0] m_rgb;
   logic [23:0] m_alive;

   typedef struct {
      int h; int v; int px; int bx; int by;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [16];

   always #5 clk = ~clk;

   vga_pixel_render dut (
      .clk(clk), .reset(reset), .enable(enable), .hpos(hpos), .vpos(vpos),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .paddle_x(paddle_x), .ball_x(ball_x),
      .ball_y(ball_y), .clr_valid(clr_valid), .clr_idx(clr_idx), .clr_ready(clr_ready),
      .load_all(load_all), .all_clear(all_clear), .rgb(rgb), .hsync_out(hsync_out),
      .vsync_out(vsync_out), .frame_start(frame_start)
   );

   // screen colour straight from the geometry rules, in active coordinates
   function automatic logic [7:0] colour(int h, int v, int px, int bx, int by, logic [23:0] al);
      int x, y, c, r;
      if (h < 144 || h >= 784 || v < 31 || v >= 511) return 8'h00;
      x = h - 144;
      y = v - 31;
      if (((x - bx) & 1023) < 8 && ((y - by) & 511) < 8) return 8'hFF;
      if (x >= px && x < px + 64 && y >= 440 && y < 448) return 8'h1F;
      if (y >= 40 && y < 100) begin
         c = x / 80;
         r = (y - 40) / 20;
         if (al[r * 8 + c] && x % 80 != 0 && (y - 40) % 20 != 0)
            return r == 0 ? 8'hE0 : r == 1 ? 8'hFC : 8'h1C;
      end
      return 8'h02;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic rdy;
      #1;
      rdy = enable && !(m_val && m_v >= 31 && m_v < 511);
      check("clr_ready", clr_ready, rdy);
      @(posedge clk);
      if (reset) begin
         m_rgb = 8'h00; m_hso = 1'b1; m_vso = 1'b1; m_fs = 1'b0; m_allc = 1'b0;
         m_alive = '1; m_val = 1'b0;
      end else if (enable) begin
         m_rgb = m_val ? colour(m_h, m_v, m_px, m_bx, m_by, m_alive) : 8'h00;
         m_hso = m_val ? m_hs : 1'b1;
         m_vso = m_val ? m_vs : 1'b1;
         m_fs = m_val && m_h == 0 && m_v == 0;
         m_allc = m_alive == 24'd0;
         if (load_all) m_alive = '1;
         else if (clr_valid && rdy && clr_idx < 24) m_alive[clr_idx] = 1'b0;
         m_val = 1'b1;
         m_h = hpos; m_v = vpos; m_hs = hsync_in; m_vs = vsync_in;
         m_px = paddle_x; m_bx = ball_x; m_by = ball_y;
      end
      #1;
      check("pipe", {rgb, hsync_out, vsync_out, frame_start, all_clear},
            {m_rgb, m_hso, m_vso, m_fs, m_allc});
      if (frame_start) fs_count++;
   endtask

   task automatic drive(int h, int v);
      hpos = 11'(h);
      vpos = 11'(v);
      hsync_in = h >= 96;
      vsync_in = v >= 2;
      tick();
   endtask

   task automatic probe(int h, int v, output logic [7:0] got);
      for (int hh = 140; hh <= h + 1; hh++) drive(hh, v);
      got = rgb;
   endtask

   initial begin
      logic [7:0] got;
      int v, bx, by;
      vecs[0]  = '{143, 100, 1000, 1000, 500, 8'h00};
      vecs[1]  = '{144,  31, 1000, 1000, 500, 8'h02};
      vecs[2]  = '{149,  76, 1000, 1000, 500, 8'hE0};
      vecs[3]  = '{224,  76, 1000, 1000, 500, 8'h02};
      vecs[4]  = '{149,  96, 1000, 1000, 500, 8'hFC};
      vecs[5]  = '{149,  76, 1000,    0,  40, 8'hFF};
      vecs[6]  = '{244, 471,  100, 1000, 500, 8'h1F};
      vecs[7]  = '{308, 471,  100, 1000, 500, 8'h02};
      vecs[8]  = '{307, 478,  100, 1000, 500, 8'h1F};
      vecs[9]  = '{149, 116, 1000, 1000, 500, 8'h1C};
      vecs[10] = '{149,  71, 1000, 1000, 500, 8'h02};
      vecs[11] = '{783, 130, 1000, 1000, 500, 8'h1C};
      vecs[12] = '{784, 130, 1000, 1000, 500, 8'h00};
      vecs[13] = '{200, 511, 1000, 1000, 500, 8'h00};
      vecs[14] = '{144,  76, 1000, 1000, 500, 8'h02};
      vecs[15] = '{223,  90, 1000, 1000, 500, 8'hE0};
      m_val = 1'b0; m_h = 0; m_v = 0; m_hs = 1'b1; m_vs = 1'b1; m_px = 0; m_bx = 0; m_by = 0;
      m_rgb = 8'h00; m_hso = 1'b1; m_vso = 1'b1; m_fs = 1'b0; m_allc = 1'b0; m_alive = '1;
      reset = 1'b1; enable = 1'b1; clr_valid = 1'b0; clr_idx = 5'd0; load_all = 1'b0;
      paddle_x = 10'd1000; ball_x = 10'd1000; ball_y = 9'd500;
      drive(0, 0);
      drive(1, 0);
      check("rst_rgb", rgb, 8'h00);
      check("rst_hsync", hsync_out, 1'b1);
      check("rst_vsync", vsync_out, 1'b1);
      check("rst_frame", frame_start, 1'b0);
      check("rst_allclr", all_clear, 1'b0);
      reset = 1'b0;

      // two frame boundaries with raster wrap
      fs_count = 0;
      for (int f = 0; f < 2; f++)
         for (int l = 0; l < 4; l++)
            for (int h = 0; h < 800; h++) drive(h, l < 2 ? 519 + l : l - 2);
      check("frame_cnt", fs_count, 2);

      for (int i = 0; i < 16; i++) begin
         paddle_x = 10'(vecs[i].px);
         ball_x = 10'(vecs[i].bx);
         ball_y = 9'(vecs[i].by);
         probe(vecs[i].h, vecs[i].v, got);
         check($sformatf("vec%0d", i), got, vecs[i].exp);
      end
      paddle_x = 10'd1000; ball_x = 10'd1000; ball_y = 9'd500;

      // clear refused during active video
      clr_valid = 1'b1; clr_idx = 5'd0;
      for (int h = 140; h < 150; h++) drive(h, 76);
      check("clr_blocked", clr_ready, 1'b0);
      clr_valid = 1'b0;
      probe(149, 76, got);
      check("brick0_kept", got, 8'hE0);
      drive(0, 515);
      drive(1, 515);
      clr_valid = 1'b1;
      check("clr_vblank", clr_ready, 1'b1);
      drive(2, 515);
      clr_valid = 1'b0;
      probe(149, 76, got);
      check("brick0_gone", got, 8'h02);

      // wipe the wall, including an out-of-range index
      drive(0, 515);
      clr_valid = 1'b1;
      clr_idx = 5'd30;
      drive(1, 515);
      for (int i = 0; i < 24; i++) begin
         clr_idx = 5'(i);
         drive(2 + i, 515);
      end
      clr_valid = 1'b0;
      drive(30, 515);
      drive(31, 515);
      check("all_clear", all_clear, 1'b1);
      clr_valid = 1'b1; clr_idx = 5'd3; load_all = 1'b1;
      drive(32, 515);
      clr_valid = 1'b0; load_all = 1'b0;
      drive(33, 515);
      drive(34, 515);
      check("reload", all_clear, 1'b0);
      probe(389, 76, got);
      check("brick3_back", got, 8'hE0);

      // reset mid-line
      for (int h = 140; h < 300; h++) drive(h, 96);
      reset = 1'b1;
      drive(300, 96);
      check("mid_rst_rgb", rgb, 8'h00);
      check("mid_rst_sync", {hsync_out, vsync_out, frame_start}, 3'b110);
      reset = 1'b0;
      probe(150, 96, got);
      check("post_rst", got, 8'hFC);

      // randomized lines with sparse enable
      for (int l = 0; l < 8; l++) begin
         v = l < 5 ? 71 + 10 * l : $urandom_range(0, 520);
         paddle_x = 10'($urandom_range(0, 600));
         bx = $urandom_range(0, 639);
         by = (v - 31 - $urandom_range(0, 7)) & 511;
         ball_x = 10'(bx);
         ball_y = 9'(by);
         if (l == 6) paddle_x = 10'(bx);
         for (int h = 100; h < 800; h++) begin
            clr_valid = ($urandom % 16) == 0;
            clr_idx = 5'($urandom_range(0, 31));
            load_all = ($urandom % 512) == 0;
            do begin
               enable = ($urandom % 4) == 0;
               drive(h, v);
            end while (!enable);
         end
      end
      enable = 1'b1; clr_valid = 1'b0; load_all = 1'b0;
      drive(0, 515);
      drive(1, 515);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
